// File: rtl/score_sequencer.sv
// Score sequencer: arbitrates line-clear and drop-point events and issues BCD
// increments to the scoreboard accumulator. Define SCORE_SEQ_STATS_EN for line/tetris counters.
module score_sequencer #(
   parameter int LEVEL_W  = 4,
   parameter int DROP_W   = 7,
   parameter int DROP_MAX = 99
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               freeze,
   input  logic [LEVEL_W-1:0] level,
   input  logic               lc_valid,
   input  logic [2:0]         lc_lines,
   output logic               lc_ready,
   input  logic               drop_valid,
   input  logic [DROP_W-1:0]  drop_pts,
   output logic               drop_ready,
   output logic [15:0]        add_digits,
   output logic               add_valid,
   output logic               busy
`ifdef SCORE_SEQ_STATS_EN
   ,
   output logic [9:0]         lines_total,
   output logic [7:0]         tetris_count
`endif
);

   // state      | meaning
   // IDLE       | waiting for a pending slot; grants when not frozen
   // LC_ISSUE   | issuing line-clear base (level+1) times, rep counts down
   // DROP_ISSUE | issuing the drop-point increment once
   typedef enum logic [1:0] {IDLE, LC_ISSUE, DROP_ISSUE} state_t;

   state_t              state;
   logic                lc_pend;
   logic                drop_pend;
   logic [2:0]          lc_lines_q;
   logic [DROP_W-1:0]   drop_pts_q;
   logic [LEVEL_W-1:0]  rep;
   logic [15:0]         digits_q;
   logic                last_grant_lc;

   logic [15:0]         lc_base;
   logic                lc_ok;
   logic [DROP_W-1:0]   drop_clamped;
   logic [6:0]          drop_bin;
   logic [15:0]         drop_bcd;
   logic                grant_lc;
   logic                grant_drop;

   always_comb begin
      lc_base = 16'h0000;
      lc_ok   = 1'b1;
      case (lc_lines_q)
         3'd1:    lc_base = 16'h0040;
         3'd2:    lc_base = 16'h0100;
         3'd3:    lc_base = 16'h0300;
         3'd4:    lc_base = 16'h1200;
         default: lc_ok   = 1'b0;
      endcase
   end

   always_comb begin
      drop_clamped = (drop_pts_q > DROP_W'(DROP_MAX)) ? DROP_W'(DROP_MAX) : drop_pts_q;
      drop_bin     = 7'(drop_clamped);
      drop_bcd     = {8'h00, 4'(drop_bin / 7'd10), 4'(drop_bin % 7'd10)};
   end

   // Round-robin only matters when both slots are pending.
   assign grant_lc   = lc_pend && (!drop_pend || !last_grant_lc);
   assign grant_drop = drop_pend && !grant_lc;

   assign lc_ready   = !lc_pend;
   assign drop_ready = !drop_pend;
   assign busy       = (state != IDLE) || lc_pend || drop_pend;

`ifdef SCORE_SEQ_STATS_EN
   logic [10:0] lines_sum;
   assign lines_sum = {1'b0, lines_total} + 11'(lc_lines_q);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         lc_pend       <= 1'b0;
         drop_pend     <= 1'b0;
         lc_lines_q    <= '0;
         drop_pts_q    <= '0;
         rep           <= '0;
         digits_q      <= '0;
         last_grant_lc <= 1'b0;
         add_digits    <= '0;
         add_valid     <= 1'b0;
`ifdef SCORE_SEQ_STATS_EN
         lines_total   <= '0;
         tetris_count  <= '0;
`endif
      end else begin
         if (lc_valid && !lc_pend) begin
            lc_pend    <= 1'b1;
            lc_lines_q <= lc_lines;
         end
         if (drop_valid && !drop_pend) begin
            drop_pend  <= 1'b1;
            drop_pts_q <= drop_pts;
         end

         case (state)
            IDLE: begin
               if (!freeze && grant_lc) begin
                  last_grant_lc <= 1'b1;
                  if (lc_ok) begin
                     state      <= LC_ISSUE;
                     digits_q   <= lc_base;
                     add_digits <= lc_base;
                     add_valid  <= 1'b1;
                     rep        <= level;
`ifdef SCORE_SEQ_STATS_EN
                     lines_total <= (lines_sum > 11'd1023) ? 10'd1023 : lines_sum[9:0];
                     if (lc_lines_q == 3'd4 && tetris_count != 8'hFF)
                        tetris_count <= tetris_count + 8'd1;
`endif
                  end else begin
                     lc_pend <= 1'b0;
                  end
               end else if (!freeze && grant_drop) begin
                  last_grant_lc <= 1'b0;
                  state         <= DROP_ISSUE;
                  digits_q      <= drop_bcd;
                  add_digits    <= drop_bcd;
                  add_valid     <= 1'b1;
               end
            end

            // An add presented last cycle is always counted, even if freeze
            // rises now; freeze only suppresses the next presentation.
            LC_ISSUE: begin
               if (add_valid) begin
                  if (rep == '0) begin
                     lc_pend    <= 1'b0;
                     add_valid  <= 1'b0;
                     add_digits <= '0;
                     state      <= IDLE;
                  end else begin
                     rep        <= rep - 1'b1;
                     add_valid  <= !freeze;
                     add_digits <= freeze ? 16'h0000 : digits_q;
                  end
               end else if (!freeze) begin
                  add_valid  <= 1'b1;
                  add_digits <= digits_q;
               end
            end

            DROP_ISSUE: begin
               if (add_valid) begin
                  drop_pend  <= 1'b0;
                  add_valid  <= 1'b0;
                  add_digits <= '0;
                  state      <= IDLE;
               end else if (!freeze) begin
                  add_valid  <= 1'b1;
                  add_digits <= digits_q;
               end
            end

            default: begin
               state      <= IDLE;
               add_valid  <= 1'b0;
               add_digits <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_score_sequencer.sv
// Directed self-checking bench for score_sequencer; works with or without SCORE_SEQ_STATS_EN.
module tb_score_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        freeze;
   logic [3:0]  level;
   logic        lc_valid;
   logic [2:0]  lc_lines;
   logic        lc_ready;
   logic        drop_valid;
   logic [6:0]  drop_pts;
   logic        drop_ready;
   logic [15:0] add_digits;
   logic        add_valid;
   logic        busy;
`ifdef SCORE_SEQ_STATS_EN
   logic [9:0]  lines_total;
   logic [7:0]  tetris_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int acc   = 0;
   int a0;

   score_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .freeze     (freeze),
      .level      (level),
      .lc_valid   (lc_valid),
      .lc_lines   (lc_lines),
      .lc_ready   (lc_ready),
      .drop_valid (drop_valid),
      .drop_pts   (drop_pts),
      .drop_ready (drop_ready),
      .add_digits (add_digits),
      .add_valid  (add_valid),
      .busy       (busy)
`ifdef SCORE_SEQ_STATS_EN
      ,
      .lines_total  (lines_total),
      .tetris_count (tetris_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic int bcd_val(input logic [15:0] d);
      return int'(d[15:12]) * 1000 + int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
   endfunction

   // Behaves like the scoreboard: adds add_digits every clock.
   always @(posedge clk) acc <= acc + bcd_val(add_digits);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic out_chk(input string tag, input logic v, input logic [15:0] d);
      chk({tag, "_valid"}, 32'(add_valid), 32'(v));
      chk({tag, "_digits"}, 32'(add_digits), 32'(d));
   endtask

   initial begin
      reset = 1'b1; freeze = 1'b0; level = 4'd0;
      lc_valid = 1'b0; lc_lines = 3'd0; drop_valid = 1'b0; drop_pts = 7'd0;
      step(); step();
      out_chk("rst", 1'b0, 16'h0000);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_lc_ready", 32'(lc_ready), 32'd1);
      chk("rst_drop_ready", 32'(drop_ready), 32'd1);
`ifdef SCORE_SEQ_STATS_EN
      chk("rst_lines", 32'(lines_total), 32'd0);
      chk("rst_tetris", 32'(tetris_count), 32'd0);
`endif
      reset = 1'b0;

      // level 0 tetris: single add of 1200
      level = 4'd0; lc_lines = 3'd4; lc_valid = 1'b1;
      step();
      lc_valid = 1'b0;
      chk("t1_lc_ready_e0", 32'(lc_ready), 32'd0);
      chk("t1_busy_e0", 32'(busy), 32'd1);
      out_chk("t1_e0", 1'b0, 16'h0000);
      step();
      out_chk("t1_e1", 1'b1, 16'h1200);
      chk("t1_lc_ready_e1", 32'(lc_ready), 32'd0);
      step();
      out_chk("t1_e2", 1'b0, 16'h0000);
      chk("t1_lc_ready_e2", 32'(lc_ready), 32'd1);
      chk("t1_busy_e2", 32'(busy), 32'd0);
`ifdef SCORE_SEQ_STATS_EN
      chk("t1_lines", 32'(lines_total), 32'd4);
      chk("t1_tetris", 32'(tetris_count), 32'd1);
`endif

      // level 2, three lines: three adds of 0300, level change mid-burst ignored
      a0 = acc;
      level = 4'd2; lc_lines = 3'd3; lc_valid = 1'b1;
      step();
      lc_valid = 1'b0;
      step();
      out_chk("t2_c1", 1'b1, 16'h0300);
      level = 4'd9;
      step();
      out_chk("t2_c2", 1'b1, 16'h0300);
      step();
      out_chk("t2_c3", 1'b1, 16'h0300);
      step();
      out_chk("t2_end", 1'b0, 16'h0000);
      chk("t2_acc", 32'(acc - a0), 32'd900);
      level = 4'd0;

      // drop 37, then clamped drop 120
      drop_pts = 7'd37; drop_valid = 1'b1;
      step();
      drop_valid = 1'b0;
      chk("t3_drop_ready", 32'(drop_ready), 32'd0);
      step();
      out_chk("t3_37", 1'b1, 16'h0037);
      step();
      out_chk("t3_37_end", 1'b0, 16'h0000);
      chk("t3_drop_ready_end", 32'(drop_ready), 32'd1);
      drop_pts = 7'd120; drop_valid = 1'b1;
      step();
      drop_valid = 1'b0;
      step();
      out_chk("t3_120", 1'b1, 16'h0099);
      step();
      out_chk("t3_120_end", 1'b0, 16'h0000);

      // simultaneous after reset: LC first (last_grant resets to DROP)
      reset = 1'b1;
      step();
      reset = 1'b0;
      level = 4'd1; lc_lines = 3'd1; lc_valid = 1'b1; drop_pts = 7'd5; drop_valid = 1'b1;
      step();
      lc_valid = 1'b0; drop_valid = 1'b0;
      step();
      out_chk("t4_lc1", 1'b1, 16'h0040);
      step();
      out_chk("t4_lc2", 1'b1, 16'h0040);
      step();
      out_chk("t4_idle", 1'b0, 16'h0000);
      chk("t4_drop_ready_idle", 32'(drop_ready), 32'd0);
      step();
      out_chk("t4_drop", 1'b1, 16'h0005);
      step();
      out_chk("t4_end", 1'b0, 16'h0000);
      chk("t4_busy_end", 32'(busy), 32'd0);
      // lone LC leaves last_grant=LC, so the next pair grants drop first
      level = 4'd0; lc_lines = 3'd2; lc_valid = 1'b1;
      step();
      lc_valid = 1'b0;
      step();
      out_chk("t4_lone", 1'b1, 16'h0100);
      step();
      lc_lines = 3'd1; lc_valid = 1'b1; drop_pts = 7'd12; drop_valid = 1'b1;
      step();
      lc_valid = 1'b0; drop_valid = 1'b0;
      step();
      out_chk("t4_pair_drop", 1'b1, 16'h0012);
      step();
      out_chk("t4_pair_idle", 1'b0, 16'h0000);
      step();
      out_chk("t4_pair_lc", 1'b1, 16'h0040);
      step();
      out_chk("t4_pair_end", 1'b0, 16'h0000);
`ifdef SCORE_SEQ_STATS_EN
      chk("t4_lines", 32'(lines_total), 32'd4);
      chk("t4_tetris", 32'(tetris_count), 32'd0);
`endif

      // freeze during a 4-rep burst; drop accepted while frozen
      a0 = acc;
      level = 4'd3; lc_lines = 3'd2; lc_valid = 1'b1;
      step();
      lc_valid = 1'b0;
      step();
      out_chk("t5_c1", 1'b1, 16'h0100);
      freeze = 1'b1;
      drop_pts = 7'd7; drop_valid = 1'b1;
      step();
      drop_valid = 1'b0;
      chk("t5_drop_ready_frz", 32'(drop_ready), 32'd0);
      out_chk("t5_frz0", 1'b0, 16'h0000);
      for (int i = 1; i < 5; i++) begin
         step();
         out_chk("t5_frz", 1'b0, 16'h0000);
      end
      chk("t5_busy_frz", 32'(busy), 32'd1);
      freeze = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         out_chk("t5_resume", 1'b1, 16'h0100);
      end
      step();
      out_chk("t5_end", 1'b0, 16'h0000);
      chk("t5_acc", 32'(acc - a0), 32'd400);
      step();
      out_chk("t5_drop", 1'b1, 16'h0007);
      step();
      out_chk("t5_drop_end", 1'b0, 16'h0000);

      // freeze in IDLE blocks the grant
      freeze = 1'b1; level = 4'd0;
      drop_pts = 7'd99; drop_valid = 1'b1;
      step();
      drop_valid = 1'b0;
      step(); step();
      out_chk("t6_frz_idle", 1'b0, 16'h0000);
      chk("t6_busy", 32'(busy), 32'd1);
      freeze = 1'b0;
      step();
      out_chk("t6_grant", 1'b1, 16'h0099);
      step();
      out_chk("t6_end", 1'b0, 16'h0000);

      // invalid line count: slot freed at grant edge, no add, no stats
      lc_lines = 3'd0; lc_valid = 1'b1;
      step();
      lc_valid = 1'b0;
      chk("t7_lc_ready_e0", 32'(lc_ready), 32'd0);
      step();
      chk("t7_lc_ready_e1", 32'(lc_ready), 32'd1);
      out_chk("t7_e1", 1'b0, 16'h0000);
`ifdef SCORE_SEQ_STATS_EN
      chk("t7_lines", 32'(lines_total), 32'd6);
`endif

      // reset mid-burst discards everything, including a payload offered at reset
      level = 4'd5; lc_lines = 3'd4; lc_valid = 1'b1;
      step();
      lc_valid = 1'b0;
      step(); step();
      out_chk("t8_burst", 1'b1, 16'h1200);
      reset = 1'b1; drop_pts = 7'd3; drop_valid = 1'b1;
      step();
      reset = 1'b0; drop_valid = 1'b0;
      out_chk("t8_rst", 1'b0, 16'h0000);
      chk("t8_lc_ready", 32'(lc_ready), 32'd1);
      chk("t8_drop_ready", 32'(drop_ready), 32'd1);
      chk("t8_busy", 32'(busy), 32'd0);
`ifdef SCORE_SEQ_STATS_EN
      chk("t8_lines", 32'(lines_total), 32'd0);
      chk("t8_tetris", 32'(tetris_count), 32'd0);
`endif
      step(); step();
      out_chk("t8_after", 1'b0, 16'h0000);
      chk("t8_busy_after", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
